// File: rtl/seq_101_tx_if.sv
// -----------------------------------------------------------------------------
// seq_101_tx_if
//
// Parallel-side handshake bundle for the seq_101_tx serial frame transmitter.
// A producer drives one payload word with a valid flag; the transmitter
// answers with ready while it is idle. A word is taken on the rising clock
// edge where both valid and ready are high.
//
// Signals:
//   in_data  [WIDTH-1:0] payload word from the producer
//   in_valid             producer has a word waiting
//   in_ready             transmitter can take a word this cycle
//
// Modports:
//   master  producer side   (drives in_data / in_valid, observes in_ready)
//   slave   transmitter side (observes in_data / in_valid, drives in_ready)
// -----------------------------------------------------------------------------
interface seq_101_tx_if #(
    parameter int WIDTH = 8
) ();

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );

endinterface : seq_101_tx_if

// File: rtl/seq_101_tx.sv
// -----------------------------------------------------------------------------
// seq_101_tx
//
// Serial frame transmitter. Each accepted word goes out on a single-bit line
// as a "101" sync preamble followed by the payload, MSB first. The line then
// idles low for GAP cycles so that a downstream Moore "101" detector sees a
// clean preamble edge on the next frame. At least one IDLE cycle follows the
// gap, so words held back-to-back are taken every 3+WIDTH+GAP+1 cycles.
//
// Parameters:
//   WIDTH  payload bits per frame (>= 1)
//   GAP    idle-low cycles after each payload (>= 1)
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous, active-high reset; discards any frame in flight
//   in_if    slave side of the valid/ready handshake (in_data, in_valid,
//            in_ready); in_ready is high only in IDLE and never during reset
//   out      serial line, Moore output of state and shift register
//   busy     high whenever a frame (preamble, payload or gap) is in progress
//   done     one-cycle pulse in the first gap cycle of each frame
//   state    current state code, exported for debug and monitoring
//            (IDLE=0, PRE1=1, PRE0=2, PRE2=3, DATA=4, GAP=5)
// -----------------------------------------------------------------------------
module seq_101_tx #(
    parameter int WIDTH = 8,
    parameter int GAP   = 2
) (
    input  logic         clk,
    input  logic         reset,
    seq_101_tx_if.slave  in_if,
    output logic         out,
    output logic         busy,
    output logic         done,
    output logic [2:0]   state
);

    // Both counters share one width, large enough to hold the bigger of
    // WIDTH and GAP. bit_cnt reaches WIDTH on the final payload edge, so the
    // width must cover WIDTH itself and not just WIDTH-1.
    localparam int MAX_CNT = (WIDTH > GAP) ? WIDTH : GAP;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_GAP = CNT_W'(GAP - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE1 = 3'd1,
        S_PRE0 = 3'd2,
        S_PRE2 = 3'd3,
        S_DATA = 3'd4,
        S_GAP  = 3'd5
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [CNT_W-1:0] bit_cnt_d;
    logic [CNT_W-1:0] gap_cnt_q;
    logic [CNT_W-1:0] gap_cnt_d;

    logic             in_ready_int;
    logic             accept;

    // Ready is decoded straight from the state register and reset, so it
    // drops the moment reset rises and returns as soon as reset releases
    // with the machine in IDLE. Unused codes 6/7 are not IDLE, so no word
    // can be taken while the machine recovers from one of them.
    assign in_ready_int   = (state_q == S_IDLE) && !reset;
    assign in_if.in_ready = in_ready_int;
    assign accept         = in_if.in_valid && in_ready_int;

    // State and datapath registers. Reset clears everything at once, so a
    // frame in flight is dropped and the line falls to 0 immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    // Next-state and datapath logic. Everything holds by default; only the
    // state that owns a register touches it. The payload word is captured
    // only on the accepting edge, so in_data is free to change while busy.
    // The shift register moves left with zero fill so its top bit is always
    // the next payload bit to drive.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_PRE1;
                    shreg_d   = in_if.in_data;
                    bit_cnt_d = '0;
                end
            end

            S_PRE1: begin
                state_d = S_PRE0;
            end

            S_PRE0: begin
                state_d = S_PRE2;
            end

            S_PRE2: begin
                state_d = S_DATA;
            end

            S_DATA: begin
                shreg_d   = shreg_q << 1;
                bit_cnt_d = bit_cnt_q + CNT_ONE;
                if (bit_cnt_q == LAST_BIT) begin
                    state_d   = S_GAP;
                    gap_cnt_d = '0;
                end
            end

            S_GAP: begin
                gap_cnt_d = gap_cnt_q + CNT_ONE;
                if (gap_cnt_q == LAST_GAP) begin
                    state_d = S_IDLE;
                end
            end

            // Codes 6 and 7 can only appear through an upset; they return to
            // IDLE on the next edge without emitting anything.
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore line output: the preamble is fixed per state, the payload comes
    // from the top of the shift register, and every other state holds low.
    always_comb begin
        out = 1'b0;
        case (state_q)
            S_PRE1:  out = 1'b1;
            S_PRE0:  out = 1'b0;
            S_PRE2:  out = 1'b1;
            S_DATA:  out = shreg_q[WIDTH-1];
            default: out = 1'b0;
        endcase
    end

    // Status outputs. done marks the first gap cycle, which is the first
    // cycle after the last payload bit has been on the line.
    always_comb begin
        busy  = (state_q != S_IDLE);
        done  = (state_q == S_GAP) && (gap_cnt_q == '0);
        state = state_q;
    end

endmodule : seq_101_tx

// File: tb/tb_seq_101_tx.sv
// -----------------------------------------------------------------------------
// tb_seq_101_tx
//
// Self-checking bench for seq_101_tx (WIDTH=8, GAP=2). A frame-level model
// tracks the position inside the current frame and looks up the expected
// line bit in the frame image {101, payload, GAP zeros}; every other output
// follows from that position. A compare process checks all outputs against
// the model on every falling edge. Directed sequences pin exact waveforms,
// a randomized phase then drives random words and reset pulses.
// -----------------------------------------------------------------------------
module tb_seq_101_tx;

    localparam int WIDTH     = 8;
    localparam int GAP       = 2;
    localparam int FRAME_LEN = 3 + WIDTH + GAP;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       out;
    logic       busy;
    logic       done;
    logic [2:0] state;

    seq_101_tx_if #(.WIDTH(WIDTH)) bus ();

    seq_101_tx #(
        .WIDTH (WIDTH),
        .GAP   (GAP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .in_if (bus),
        .out   (out),
        .busy  (busy),
        .done  (done),
        .state (state)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    bit checking_on = 1'b0;

    // Frame-level reference: pos is -1 when idle, otherwise the index of the
    // current cycle inside the frame image.
    int                   pos   = -1;
    logic [FRAME_LEN-1:0] frame = '0;

    // Behavioural 101 detector fed by the transmitter line.
    logic [1:0] det_hist = '0;
    logic       det_q    = 1'b0;

    function automatic logic [FRAME_LEN-1:0] build_frame(input logic [WIDTH-1:0] d);
        return {3'b101, d, {GAP{1'b0}}};
    endfunction

    function automatic logic exp_out();
        return (pos < 0) ? 1'b0 : frame[FRAME_LEN-1-pos];
    endfunction

    function automatic logic [2:0] exp_state();
        if (pos < 0)
            return 3'd0;
        else if (pos < 3)
            return 3'(pos + 1);
        else if (pos < 3 + WIDTH)
            return 3'd4;
        else
            return 3'd5;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [WIDTH-1:0] data);
        @(posedge clk);
        #2;
        bus.in_valid = valid;
        bus.in_data  = data;
    endtask

    // Reference model: a word is taken on any edge where the model is idle,
    // valid is high and reset is low; the frame then runs for FRAME_LEN
    // cycles and is followed by at least one idle cycle.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pos <= -1;
        end else if (pos < 0) begin
            if (bus.in_valid) begin
                frame <= build_frame(bus.in_data);
                pos   <= 0;
            end
        end else if (pos == FRAME_LEN - 1) begin
            pos <= -1;
        end else begin
            pos <= pos + 1;
        end
    end

    // Moore 101 detector: output rises the cycle after the final 1 is seen.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            det_hist <= '0;
            det_q    <= 1'b0;
        end else begin
            det_hist <= {det_hist[0], out};
            det_q    <= ({det_hist, out} == 3'b101);
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (checking_on) begin
            checkOutput("out",      32'(out),          32'(exp_out()));
            checkOutput("busy",     32'(busy),         32'(pos >= 0));
            checkOutput("done",     32'(done),         32'(pos == 3 + WIDTH));
            checkOutput("in_ready", 32'(bus.in_ready), 32'((pos < 0) && !reset));
            checkOutput("state",    32'(state),        32'(exp_state()));
        end
    end

    initial begin
        logic [12:0] seq13;
        logic [12:0] done13;
        logic [26:0] seq27;
        logic [10:0] seq11;
        int          spacing;
        int          rises;
        logic        det_prev;
        logic [2:0]  prev_state;

        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        reset        = 1'b1;
        checking_on  = 1'b1;
        repeat (3) @(posedge clk);

        // Release and check ready returns at once.
        #2;
        reset = 1'b0;
        #1;
        checkOutput("ready_after_reset", 32'(bus.in_ready), 32'd1);
        checkOutput("out_after_reset",   32'(out),          32'd0);
        repeat (2) @(posedge clk);

        // Single A5 frame; in_data changes to 3C right after the accept.
        applyStimulus(1'b1, 8'hA5);
        @(posedge clk);
        #2;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h3C;
        seq13  = '0;
        done13 = '0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k <= 13) begin
                seq13  = {seq13[11:0], out};
                done13 = {done13[11:0], done};
            end
            if (k == 13) checkOutput("a5_ready_c13", 32'(bus.in_ready), 32'd0);
            if (k == 14) checkOutput("a5_ready_c14", 32'(bus.in_ready), 32'd1);
        end
        checkOutput("a5_line", 32'(seq13),  32'(13'b1011010010100));
        checkOutput("a5_done", 32'(done13), 32'(13'b0000000000010));

        // Back-to-back FF then 00 with in_valid held high.
        applyStimulus(1'b1, 8'hFF);
        @(posedge clk);
        #2;
        bus.in_data = 8'h00;
        seq27   = '0;
        spacing = -1;
        for (int k = 1; k <= 27; k++) begin
            @(negedge clk);
            seq27 = {seq27[25:0], out};
            if (spacing < 0 && bus.in_ready) spacing = k;
        end
        bus.in_valid = 1'b0;
        checkOutput("b2b_spacing", 32'(spacing), 32'd14);
        checkOutput("b2b_line",    32'(seq27),
                    32'(27'b101_11111111_00_0_101_00000000_00));

        // Reset on the 4th payload cycle of an FF frame, then an 81 frame.
        applyStimulus(1'b1, 8'hFF);
        @(posedge clk);
        #2;
        bus.in_valid = 1'b0;
        for (int k = 1; k <= 7; k++) @(negedge clk);
        checkOutput("pre_reset_out",   32'(out),   32'd1);
        checkOutput("pre_reset_state", 32'(state), 32'd4);
        #2;
        reset        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h81;
        #1;
        checkOutput("reset_out",   32'(out),          32'd0);
        checkOutput("reset_state", 32'(state),        32'd0);
        checkOutput("reset_busy",  32'(busy),         32'd0);
        checkOutput("reset_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("release_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #2;
        bus.in_valid = 1'b0;
        seq11 = '0;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            seq11 = {seq11[9:0], out};
        end
        checkOutput("x81_line", 32'(seq11), 32'(11'b10110000001));
        repeat (5) @(negedge clk);

        // Loopback into the 101 detector with two 00 frames.
        applyStimulus(1'b1, 8'h00);
        rises      = 0;
        @(negedge clk);
        det_prev   = det_q;
        prev_state = state;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (det_q && !det_prev) begin
                rises++;
                checkOutput("det_rise_state", 32'(state),      32'd4);
                checkOutput("det_prev_state", 32'(prev_state), 32'd3);
            end
            det_prev   = det_q;
            prev_state = state;
            if (k == 20) bus.in_valid = 1'b0;
        end
        checkOutput("det_rises", 32'(rises), 32'd2);

        // Randomized traffic with occasional reset pulses.
        for (int n = 0; n < 600; n++) begin
            @(posedge clk);
            #2;
            bus.in_valid = ($urandom_range(0, 2) == 0);
            bus.in_data  = WIDTH'($urandom);
            reset        = ($urandom_range(0, 79) == 0);
        end
        @(posedge clk);
        #2;
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        #1;
        checking_on = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_seq_101_tx
